// File: rtl/encoder83_event.sv
// encoder83_event: sequential 8-to-3 event encoder.
// Rising edges on the request lines are latched into a pending mask. Pending
// events are presented one at a time as a 3-bit index on a valid/ready port.
// Optional feature macro: ENC83_ROUND_ROBIN_EN.
//   Defined: the search for the next index starts one above the last grant
//            and wraps around.
//   Undefined: fixed priority, where bit 0 has the highest priority.
module encoder83_event #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] cap;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] pending_next;
    logic             overflow_next;
    logic             accept;

    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] last_grant_next;

    // Lowest set bit of the mask. The caller only uses the result when the mask is non-zero.
    function automatic logic [IDX_W-1:0] sel_fixed(input logic [N_REQ-1:0] mask);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

`ifdef ENC83_ROUND_ROBIN_EN
    // First set bit, searching upward from last+1 with wrap-around.
    // The downward loop lets the closest candidate overwrite the farther ones.
    function automatic logic [IDX_W-1:0] sel_rr(input logic [N_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] start;
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] r;
        start = last + 1'b1;
        r     = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (mask[cand]) begin
                r = cand;
            end
        end
        return r;
    endfunction
`endif

    // A valid index is presented exactly while the FSM is in PRESENT.
    assign out_valid = (state == PRESENT);
    assign accept    = out_valid && out_ready;

    // Pick the next index to present from the registered pending mask.
    always_comb begin
        sel_idx = '0;
`ifdef ENC83_ROUND_ROBIN_EN
        sel_idx = sel_rr(pending, last_grant);
`else
        sel_idx = sel_fixed(pending);
`endif
    end

    // Edge capture, handshake clear and overflow detection. When a bit is both set and cleared in one cycle, the set wins.
    always_comb begin
        rise          = req & ~req_q;
        cap           = en ? rise : '0;
        clr           = accept ? (N_REQ'(1) << out_idx) : '0;
        pending_next  = (pending & ~clr) | cap;
        overflow_next = |(cap & pending & ~clr);
    end

    // Next-state logic. The index is latched on entry to PRESENT and holds until the handshake.
    always_comb begin
        state_next      = state;
        idx_next        = out_idx;
        last_grant_next = last_grant;
        unique case (state)
            IDLE: begin
                if (pending != '0) begin
                    idx_next   = sel_idx;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (accept) begin
                    last_grant_next = out_idx;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request history, pending mask and the overflow pulse. The request history updates even when capture is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            req_q    <= req;
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

    // FSM state, the presented index and the last granted index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_idx    <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
        end else begin
            state      <= state_next;
            out_idx    <= idx_next;
            last_grant <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_encoder83_event.sv
// tb_encoder83_event: directed bench for encoder83_event with a cycle-level
// reference model and a per-cycle compare process.
module tb_encoder83_event;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_req_q [8];
    bit m_pend  [8];
    bit m_valid;
    int m_idx;
    int m_last;
    bit m_ovf;
    bit started = 1'b0;

    int dut_log [$];
    int exp_arr [8];

    always #5 clk = ~clk;

    encoder83_event dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    // Compare one value, count it, and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive every input. Inputs change shortly after a rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q, input logic rdy);
        rst       = r;
        en        = e;
        req       = q;
        out_ready = rdy;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Compare the accepted index sequence with exp_arr[0..n-1], then clear the log.
    task automatic checkLog(input string name, input int n);
        checkOutput({name, "_count"}, dut_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < dut_log.size()) begin
                checkOutput(name, dut_log[i], exp_arr[i]);
            end
        end
        dut_log.delete();
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Choose the next event from the model's pending set (priority order or rotation).
    function automatic int model_pick();
        int start;
        int b;
`ifdef ENC83_ROUND_ROBIN_EN
        start = (m_last + 1) % 8;
`else
        start = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            b = (start + k) % 8;
            if (m_pend[b]) return b;
        end
        return 0;
    endfunction

    // Reference model, advanced once per rising edge.
    always @(posedge clk) begin : model_b
        bit nxt [8];
        bit acc;
        bit any;
        bit ovf;
        bit r;
        bit c;
        bit cl;
        started = 1'b1;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_req_q[i] = 1'b0;
                m_pend[i]  = 1'b0;
            end
            m_valid = 1'b0;
            m_idx   = 0;
            m_ovf   = 1'b0;
            m_last  = 7;
        end else begin
            acc = m_valid && out_ready;
            ovf = 1'b0;
            any = 1'b0;
            for (int i = 0; i < 8; i++) begin
                r  = req[i] && !m_req_q[i];
                c  = en && r;
                cl = acc && (m_idx == i);
                if (c && m_pend[i] && !cl) ovf = 1'b1;
                nxt[i] = (m_pend[i] && !cl) || c;
                if (m_pend[i]) any = 1'b1;
                m_req_q[i] = req[i];
            end
            if (!m_valid) begin
                if (any) begin
                    m_idx   = model_pick();
                    m_valid = 1'b1;
                end
            end else if (acc) begin
                m_valid = 1'b0;
                m_last  = m_idx;
            end
            m_pend = nxt;
            m_ovf  = ovf;
        end
    end

    // Compare every DUT output with the model on each falling edge.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("cmp_valid", out_valid, m_valid);
            checkOutput("cmp_idx", out_idx, m_idx);
            checkOutput("cmp_pending", pending, model_pending());
            checkOutput("cmp_overflow", overflow, m_ovf);
        end
    end

    // Record each index the DUT hands over at the next rising edge.
    always @(negedge clk) begin
        if (started && !rst && out_valid && out_ready) begin
            dut_log.push_back(int'(out_idx));
        end
    end

    // Directed scenarios with hand-computed expectations
    initial begin
        $display("[TB] start");

        // Reset is held with all request lines high.
        applyStimulus(1, 1, 8'hFF, 0);
        step(2);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_overflow", overflow, 0);
        applyStimulus(0, 1, 8'hFF, 0);
        step(1);
        checkOutput("t1_pending_ff", pending, 8'hFF);
        checkOutput("t1_valid_wait", out_valid, 0);
        applyStimulus(0, 1, 8'hFF, 1);
        step(20);
        checkOutput("t1_drained", pending, 0);
        checkOutput("t1_idle", out_valid, 0);
        exp_arr = '{0, 1, 2, 3, 4, 5, 6, 7};
        checkLog("t1_order", 8);

        // Single event on bit 5.
        applyStimulus(0, 1, 8'h00, 1);
        step(1);
        applyStimulus(0, 1, 8'h20, 1);
        step(1);
        checkOutput("t2_pending", pending, 8'h20);
        checkOutput("t2_valid_lat1", out_valid, 0);
        applyStimulus(0, 1, 8'h00, 1);
        step(1);
        checkOutput("t2_valid", out_valid, 1);
        checkOutput("t2_idx", out_idx, 5);
        step(1);
        checkOutput("t2_valid_drop", out_valid, 0);
        checkOutput("t2_pending_clr", pending, 0);
        exp_arr[0] = 5;
        checkLog("t2_order", 1);

        // Three events at once, each followed by an idle bubble.
        applyStimulus(0, 1, 8'h94, 1);
        step(1);
        checkOutput("t3_pending", pending, 8'h94);
        applyStimulus(0, 1, 8'h00, 1);
        for (int k = 0; k < 6; k++) begin
            step(1);
            checkOutput("t3_bubble", out_valid, (k % 2 == 0) ? 1 : 0);
        end
        checkOutput("t3_drained", pending, 0);
`ifdef ENC83_ROUND_ROBIN_EN
        exp_arr = '{7, 2, 4, 0, 0, 0, 0, 0};
`else
        exp_arr = '{2, 4, 7, 0, 0, 0, 0, 0};
`endif
        checkLog("t3_order", 3);

        // A presented index stays stable while new events are captured.
        applyStimulus(0, 1, 8'h08, 0);
        step(1);
        applyStimulus(0, 1, 8'h00, 0);
        step(1);
        checkOutput("t4_valid", out_valid, 1);
        checkOutput("t4_idx", out_idx, 3);
        applyStimulus(0, 1, 8'h02, 0);
        step(1);
        checkOutput("t4_idx_hold", out_idx, 3);
        checkOutput("t4_pending", pending, 8'h0A);
        applyStimulus(0, 1, 8'h00, 0);
        step(1);
        checkOutput("t4_idx_hold2", out_idx, 3);
        applyStimulus(0, 1, 8'h00, 1);
        step(1);
        checkOutput("t4_accept", out_valid, 0);
        checkOutput("t4_pending_left", pending, 8'h02);
        step(1);
        checkOutput("t4_next_valid", out_valid, 1);
        checkOutput("t4_next_idx", out_idx, 1);
        step(1);
        checkOutput("t4_drained", pending, 0);
        exp_arr = '{3, 1, 0, 0, 0, 0, 0, 0};
        checkLog("t4_order", 2);

        // Overflow on a bit that is already pending; set wins over clear.
        applyStimulus(0, 1, 8'h40, 0);
        step(1);
        applyStimulus(0, 1, 8'h00, 0);
        step(1);
        checkOutput("t5_idx", out_idx, 6);
        applyStimulus(0, 1, 8'h40, 0);
        step(1);
        checkOutput("t5_overflow", overflow, 1);
        checkOutput("t5_pending_same", pending, 8'h40);
        applyStimulus(0, 1, 8'h00, 0);
        step(1);
        checkOutput("t5_overflow_pulse", overflow, 0);
        applyStimulus(0, 1, 8'h40, 1);
        step(1);
        checkOutput("t5_set_wins", pending, 8'h40);
        checkOutput("t5_no_overflow", overflow, 0);
        checkOutput("t5_accepted", out_valid, 0);
        applyStimulus(0, 1, 8'h00, 1);
        step(1);
        checkOutput("t5_again_idx", out_idx, 6);
        checkOutput("t5_again_valid", out_valid, 1);
        step(1);
        checkOutput("t5_drained", pending, 0);
        exp_arr = '{6, 6, 0, 0, 0, 0, 0, 0};
        checkLog("t5_order", 2);

        // The selection policy after granting index 0.
        applyStimulus(0, 1, 8'h01, 0);
        step(1);
        applyStimulus(0, 1, 8'h00, 0);
        step(1);
        checkOutput("t6_idx0", out_idx, 0);
        applyStimulus(0, 1, 8'h21, 1);
        step(1);
        checkOutput("t6_pending", pending, 8'h21);
        checkOutput("t6_no_overflow", overflow, 0);
        applyStimulus(0, 1, 8'h00, 1);
        step(1);
`ifdef ENC83_ROUND_ROBIN_EN
        checkOutput("t6_next_idx", out_idx, 5);
        exp_arr = '{0, 5, 0, 0, 0, 0, 0, 0};
`else
        checkOutput("t6_next_idx", out_idx, 0);
        exp_arr = '{0, 0, 5, 0, 0, 0, 0, 0};
`endif
        step(3);
        checkOutput("t6_drained", pending, 0);
        checkLog("t6_order", 3);

        // An edge seen while capture is disabled is lost.
        applyStimulus(0, 0, 8'h10, 1);
        step(1);
        checkOutput("t7_no_capture", pending, 0);
        applyStimulus(0, 1, 8'h10, 1);
        step(2);
        checkOutput("t7_still_lost", pending, 0);
        checkOutput("t7_idle", out_valid, 0);
        applyStimulus(0, 1, 8'h00, 1);
        step(1);

        // Reset while an index is presented discards the event.
        applyStimulus(0, 1, 8'h08, 0);
        step(1);
        applyStimulus(0, 1, 8'h00, 0);
        step(1);
        checkOutput("t8_valid", out_valid, 1);
        applyStimulus(1, 1, 8'h00, 0);
        step(1);
        checkOutput("t8_rst_valid", out_valid, 0);
        checkOutput("t8_rst_pending", pending, 0);
        checkOutput("t8_rst_idx", out_idx, 0);
        applyStimulus(0, 1, 8'h00, 1);
        step(2);
        checkOutput("t8_after", out_valid, 0);
        checkLog("t8_order", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
